// File: rtl/framer_pkg.sv
// Shared types and constants for the pixel-stream framer.
// The state names describe the next byte the framer will load into its output register.
package framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC1,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    CSUM
  } framer_state_e;

  localparam logic [7:0] FRAMER_SYNC0       = 8'hA5;
  localparam logic [7:0] FRAMER_SYNC1       = 8'h5A;
  localparam int         FRAMER_FRAME_BYTES = 4800;

endpackage

// File: rtl/framer_out_reg.sv
// One-entry valid/ready output register for the framer.
// The slot is free when it is empty or is draining this cycle.
module framer_out_reg (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       drain_ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       slot_free
);

  assign slot_free = !valid || drain_ready;

  // A load replaces a draining byte in the same cycle; with no load the slot empties.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data  <= 8'h00;
      valid <= 1'b0;
    end else if (load && slot_free) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (drain_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_framer.sv
// Wraps the packed pixel byte stream into frames: sync0, sync1, length hi/lo, payload, checksum.
// Upstream is held off while header and checksum bytes are emitted.
module frame_framer
  import framer_pkg::*;
#(
  parameter int         frame_bytes_p = FRAMER_FRAME_BYTES,
  parameter logic [7:0] sync0_p       = FRAMER_SYNC0,
  parameter logic [7:0] sync1_p       = FRAMER_SYNC1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_done_o
);

  localparam int                 CNT_W     = $clog2(frame_bytes_p + 1);
  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(frame_bytes_p - 1);
  localparam logic [15:0]        FRAME_LEN = 16'(frame_bytes_p);

  if (frame_bytes_p < 1 || frame_bytes_p > 65535) begin : g_bad_frame_bytes
    $error("frame_framer: frame_bytes_p must be within 1..65535");
  end

  framer_state_e    state_q, state_d;
  logic [7:0]       csum_q, csum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             csum_in_reg_q;

  logic             load;
  logic [7:0]       load_data;
  logic             slot_free;

  framer_out_reg u_out_reg (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load        (load),
    .load_data   (load_data),
    .drain_ready (ready_i),
    .data        (data_o),
    .valid       (valid_o),
    .slot_free   (slot_free)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      csum_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tracks whether the byte sitting in the output register is the checksum.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      csum_in_reg_q <= 1'b0;
    end else if (load) begin
      csum_in_reg_q <= (state_q == CSUM);
    end else if (ready_i) begin
      csum_in_reg_q <= 1'b0;
    end
  end

  assign frame_done_o = valid_o && ready_i && csum_in_reg_q;

  always_comb begin
    state_d   = state_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_data = 8'h00;
    ready_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i && slot_free) begin
          load      = 1'b1;
          load_data = sync0_p;
          csum_d    = 8'h00;
          cnt_d     = '0;
          state_d   = SYNC1;
        end
      end
      SYNC1: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = sync1_p;
          state_d   = LEN_HI;
        end
      end
      LEN_HI: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = FRAME_LEN[15:8];
          state_d   = LEN_LO;
        end
      end
      LEN_LO: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = FRAME_LEN[7:0];
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        ready_o = slot_free;
        if (valid_i && slot_free) begin
          load      = 1'b1;
          load_data = data_i;
          csum_d    = csum_q + data_i;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = csum_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_framer.sv
// Directed bench for frame_framer: a 4-byte-frame instance for hand-computed vectors
// and an 8-byte-frame instance driven with upstream gaps and random downstream stalls.
module tb_frame_framer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  logic [7:0] in_data4, out_data4, in_data8, out_data8;
  logic in_valid4, in_ready4, out_valid4, out_ready4, done4;
  logic in_valid8, in_ready8, out_valid8, out_ready8, done8;

  frame_framer #(.frame_bytes_p(4), .sync0_p(8'hA5), .sync1_p(8'h5A)) dut4 (
    .clk_i(clk), .reset_i(reset), .data_i(in_data4), .valid_i(in_valid4),
    .ready_o(in_ready4), .data_o(out_data4), .valid_o(out_valid4),
    .ready_i(out_ready4), .frame_done_o(done4));

  frame_framer #(.frame_bytes_p(8), .sync0_p(8'hA5), .sync1_p(8'h5A)) dut8 (
    .clk_i(clk), .reset_i(reset), .data_i(in_data8), .valid_i(in_valid8),
    .ready_o(in_ready8), .data_o(out_data8), .valid_o(out_valid8),
    .ready_i(out_ready8), .frame_done_o(done8));

  logic [7:0] out4_q[$], exp4_q[$], out8_q[$], exp8_q[$];
  int time4_q[$], done4_q[$], done8_q[$];
  logic stall4 = 1'b0, stall8 = 1'b0;
  logic [7:0] hold4_data = 8'h00, hold8_data = 8'h00;
  logic rand_done = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Output monitors: record handshaked bytes and check stability under backpressure.
  always @(negedge clk) begin
    if (reset) begin
      stall4 = 1'b0;
    end else begin
      if (stall4) checkOutput("hold4", {23'b0, out_valid4, out_data4}, {23'b0, 1'b1, hold4_data});
      if (out_valid4 && out_ready4) begin
        if (done4) done4_q.push_back(out4_q.size());
        out4_q.push_back(out_data4);
        time4_q.push_back(cycle);
      end
      stall4 = out_valid4 && !out_ready4;
      hold4_data = out_data4;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stall8 = 1'b0;
    end else begin
      if (stall8) checkOutput("hold8", {23'b0, out_valid8, out_data8}, {23'b0, 1'b1, hold8_data});
      if (out_valid8 && out_ready8) begin
        if (done8) done8_q.push_back(out8_q.size());
        out8_q.push_back(out_data8);
      end
      stall8 = out_valid8 && !out_ready8;
      hold8_data = out_data8;
    end
  end

  // Offer one byte upstream; called and returns just after a rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    in_data4 = b;
    in_valid4 = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready4) break;
      n++;
      if (n > 100) begin
        checkOutput("upstream_wait4", n, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic applyStimulusWide(input logic [7:0] b);
    int n = 0;
    in_data8 = b;
    in_valid8 = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready8) break;
      n++;
      if (n > 200) begin
        checkOutput("upstream_wait8", n, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic sendFrame4(input logic [7:0] b0, b1, b2, b3, csum);
    exp4_q.push_back(8'hA5); exp4_q.push_back(8'h5A);
    exp4_q.push_back(8'h00); exp4_q.push_back(8'h04);
    exp4_q.push_back(b0); exp4_q.push_back(b1);
    exp4_q.push_back(b2); exp4_q.push_back(b3);
    exp4_q.push_back(csum);
    applyStimulus(b0);
    applyStimulus(b1);
    applyStimulus(b2);
    applyStimulus(b3);
  endtask

  task automatic waitDrain(input int which, input int n, input int limit);
    int k = 0;
    while (((which == 4) ? out4_q.size() : out8_q.size()) < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic compareStream4(input string tag, input int frames);
    checkOutput({tag, "_len"}, out4_q.size(), exp4_q.size());
    for (int i = 0; i < exp4_q.size(); i++)
      if (i < out4_q.size()) checkOutput($sformatf("%s[%0d]", tag, i), out4_q[i], exp4_q[i]);
    checkOutput({tag, "_done_cnt"}, done4_q.size(), frames);
    for (int i = 0; i < done4_q.size(); i++)
      checkOutput($sformatf("%s_done_idx%0d", tag, i), done4_q[i], 9 * i + 8);
    out4_q.delete(); exp4_q.delete(); time4_q.delete(); done4_q.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_data4 = 8'h00; in_valid4 = 1'b0; out_ready4 = 1'b1;
    in_data8 = 8'h00; in_valid8 = 1'b0; out_ready8 = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("rst_valid_o", out_valid4, 0);
    checkOutput("rst_data_o", out_data4, 0);
    checkOutput("rst_ready_o", in_ready4, 0);
    checkOutput("rst_done", done4, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] basic frame");
    sendFrame4(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
    waitDrain(4, 9, 100);
    compareStream4("basic", 1);

    $display("[TB] checksum wrap");
    sendFrame4(8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01);
    waitDrain(4, 9, 100);
    compareStream4("wrap", 1);

    $display("[TB] backpressure on LEN_HI");
    fork
      sendFrame4(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
      begin : bp_ctl
        int k = 0;
        while (!(out_valid4 && out_data4 == 8'h00) && k < 50) begin
          @(posedge clk); #1;
          k++;
        end
        out_ready4 = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("bp_data_o", out_data4, 8'h00);
          checkOutput("bp_valid_o", out_valid4, 1);
          checkOutput("bp_ready_o", in_ready4, 0);
        end
        @(posedge clk); #1;
        out_ready4 = 1'b1;
      end
    join
    waitDrain(4, 9, 100);
    compareStream4("bp", 1);

    $display("[TB] async reset mid-frame");
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_valid_o", out_valid4, 0);
    checkOutput("rst_mid_ready_o", in_ready4, 0);
    checkOutput("rst_mid_data_o", out_data4, 0);
    checkOutput("rst_mid_prefix", out4_q.size(), 5);
    @(posedge clk); #1;
    reset = 1'b0;
    out4_q.delete(); time4_q.delete(); done4_q.delete();
    sendFrame4(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    waitDrain(4, 9, 100);
    compareStream4("after_rst", 1);

    $display("[TB] back-to-back frames");
    sendFrame4(8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
    sendFrame4(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
    waitDrain(4, 18, 100);
    if (time4_q.size() >= 18) begin
      checkOutput("b2b_gap", time4_q[9] - time4_q[8], 1);
      checkOutput("b2b_span", time4_q[17] - time4_q[0], 17);
    end else begin
      checkOutput("b2b_bytes", time4_q.size(), 18);
    end
    compareStream4("b2b", 2);

    $display("[TB] gaps and random ready, 8-byte frames");
    fork
      begin : rnd_drv
        logic [7:0] b, sum;
        for (int f = 0; f < 3; f++) begin
          sum = 8'h00;
          exp8_q.push_back(8'hA5); exp8_q.push_back(8'h5A);
          exp8_q.push_back(8'h00); exp8_q.push_back(8'h08);
          for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            sum = sum + b;
            exp8_q.push_back(b);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            applyStimulusWide(b);
          end
          exp8_q.push_back(sum);
        end
        waitDrain(8, 39, 400);
        rand_done = 1'b1;
      end
      begin : rnd_ready
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready8 = ($urandom_range(0, 3) != 0);
        end
        out_ready8 = 1'b1;
      end
    join
    checkOutput("rand_len", out8_q.size(), 39);
    for (int i = 0; i < exp8_q.size(); i++)
      if (i < out8_q.size()) checkOutput($sformatf("rand[%0d]", i), out8_q[i], exp8_q[i]);
    checkOutput("rand_done_cnt", done8_q.size(), 3);
    for (int i = 0; i < done8_q.size(); i++)
      checkOutput($sformatf("rand_done_idx%0d", i), done8_q[i], 13 * i + 12);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/frame_framer.md
# frame_framer

Wraps the 8-bit packed pixel stream into self-delimiting frames for the serial link to the ESP host: sync word, 16-bit payload length, payload, 8-bit checksum. Sits directly downstream of the 2-bit pixel packer and consumes its byte stream over valid/ready. It stalls the packer while emitting header and checksum bytes. It feeds the link transmitter through a registered valid/ready output.

## Interface
- `frame_bytes_p`, 4800: payload bytes per frame (160x120 at 2 bpp); legal range 1..65535
- `sync0_p`, 8'hA5: first sync byte
- `sync1_p`, 8'h5A: second sync byte
- `clk_i` in 1: clock
- `reset_i` in 1: reset; one clock; reset is asynchronous and active-high
- `data_i` in 8: packed payload byte from packer
- `valid_i` in 1: `data_i` valid
- `ready_o` out 1: byte accepted when `valid_i && ready_o`
- `data_o` out 8: framed byte to transmitter
- `valid_o` out 1: `data_o` valid; held with `data_o` stable until accepted
- `ready_i` in 1: transmitter accepts when `valid_o && ready_i`
- `frame_done_o` out 1: one-cycle pulse on the cycle the checksum byte handshakes out

## Operation
- Output stage: one-entry register. Slot free = `!valid_o || ready_i`. A byte is loaded only when the slot is free. If the slot is not refilled while draining, `valid_o` drops.
- FSM states, named for the next byte to load:
  - IDLE: when `valid_i` and slot free, load `sync0_p`, clear checksum and payload count, go to SYNC1. `ready_o`=0; the first payload byte stays held upstream.
  - SYNC1: load `sync1_p` -> LEN_HI.
  - LEN_HI: load `frame_bytes_p[15:8]` -> LEN_LO.
  - LEN_LO: load `frame_bytes_p[7:0]` -> PAYLOAD.
  - PAYLOAD: `ready_o` = slot free. On in-fire, load `data_i`, checksum += `data_i` mod 256, count += 1. When accepting byte index `frame_bytes_p-1`, go to CSUM.
  - CSUM: load checksum -> IDLE. `frame_done_o` pulses when this byte is accepted downstream.
- `ready_o` is 0 in every state except PAYLOAD.
- Header/CSUM loads advance only when the slot is free; otherwise the state holds.
- Checksum is the 8-bit sum of payload bytes only, wrapping mod 256. Header bytes are excluded.
- Payload counter width is `$clog2(frame_bytes_p+1)`. It is compared against `frame_bytes_p-1`.
- `valid_i` deasserting mid-payload: the FSM waits in PAYLOAD indefinitely; the frame is not aborted.

## Timing
- Reset (async assert, sync deassert assumed at top level) values:
  - `valid_o`=0, `data_o`=0, `ready_o`=0, `frame_done_o`=0
  - state=IDLE, checksum=0, count=0
- Reset mid-frame discards the partial frame; no checksum is emitted. The next frame starts with `sync0_p`.
- Latency: a payload byte accepted at cycle t is on `data_o` at t+1.
- `valid_i` rising in IDLE at cycle t (slot free): `sync0_p` is on `data_o` at t+1.
- With `ready_i` tied high, first payload accept is at t+4, and `sync0_p`, `sync1_p`, LEN_HI, LEN_LO appear on `data_o` at t+1..t+4.
- Minimum period: `frame_bytes_p+5` cycles per frame.
- Back-to-back frames: after the CSUM load, IDLE may load the next `sync0_p` on the next free cycle; there are no bubbles with `ready_i`=1.
- Simultaneous drain and load in the same cycle is required for full throughput.
- `data_o` must not change while `valid_o && !ready_i`.

## Structure
- Package `framer_pkg`:
  - state enum typedef `framer_state_e` (IDLE, SYNC1, LEN_HI, LEN_LO, PAYLOAD, CSUM)
  - default sync constants `FRAMER_SYNC0`, `FRAMER_SYNC1`
- Sub-module `framer_out_reg`: one-entry 8-bit valid/ready register with async active-high reset. It provides `slot_free` to the FSM.
- Elaboration assertion: `frame_bytes_p` within 1..65535.

## Test plan
- Basic frame (`frame_bytes_p`=4, `ready_i`=1): input 11 22 33 44 -> output A5 5A 00 04 11 22 33 44 AA. `frame_done_o` pulses once, on the AA handshake.
- Checksum wrap (`frame_bytes_p`=4): input FF FF 01 02 -> checksum byte 01.
- Backpressure: `ready_i`=0 for 3 cycles while LEN_HI is on `data_o` -> `data_o`=00 and `valid_o`=1 held stable, `ready_o`=0 throughout. The sequence resumes unchanged.
- Upstream gaps plus random `ready_i` (`frame_bytes_p`=8, 3 frames) -> the byte stream matches the reference model exactly, with 13 bytes per frame and 3 `frame_done_o` pulses.
- Reset asserted asynchronously after the 2nd payload byte -> `valid_o`/`ready_o` are 0 immediately. The next frame restarts with A5 5A and a fresh checksum.
- Back-to-back frames with `ready_i`=1 -> the second A5 follows the first checksum byte with no idle cycle.
